// File: rtl/motor_fault_pkg.sv
// Shared definitions for the motor fault classifier: fault codes, default
// classification thresholds, the debounce FSM state type and the window
// classification function.
package motor_fault_pkg;

  localparam logic [1:0] FAULT_HEALTHY = 2'b00;
  localparam logic [1:0] FAULT_BEARING = 2'b01;
  localparam logic [1:0] FAULT_ROTOR   = 2'b10;
  localparam logic [1:0] FAULT_STATOR  = 2'b11;

  localparam int DEF_TH_STATOR  = -2400;
  localparam int DEF_TH_BEARING = 2800;
  localparam int DEF_TH_ROTOR   = 1200;

  typedef enum logic {StAcq, StLock} state_e;

  // Priority order: stator, bearing, rotor, healthy. All thresholds inclusive.
  function automatic logic [1:0] classify(input int sum, input int th_stator,
                                          input int th_bearing, input int th_rotor);
    if (sum <= th_stator) begin
      return FAULT_STATOR;
    end else if (sum >= th_bearing) begin
      return FAULT_BEARING;
    end else if (sum >= th_rotor) begin
      return FAULT_ROTOR;
    end
    return FAULT_HEALTHY;
  endfunction

endpackage

// File: rtl/motor_fault_classifier_window_accumulator.sv
// Window accumulator: sums 2**WIN_LOG2 valid samples per window.
//   clk, rst        clock, synchronous active-high reset
//   clear_i         drop the partial window
//   sample_valid_i  sample qualifier
//   sample_i        signed sample
//   close_o         this cycle accepts the last sample of a window
//   close_sum_o     sum including this cycle's sample (meaningful with close_o)
//   win_done_o      registered pulse the cycle after close_o
//   win_sum_o       registered window sum, held until the next window
module window_accumulator #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned WIN_LOG2 = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear_i,
  input  logic                                sample_valid_i,
  input  logic signed [SAMPLE_W-1:0]          sample_i,
  output logic                                close_o,
  output logic signed [SAMPLE_W+WIN_LOG2-1:0] close_sum_o,
  output logic                                win_done_o,
  output logic signed [SAMPLE_W+WIN_LOG2-1:0] win_sum_o
);

  localparam int unsigned SumW = SAMPLE_W + WIN_LOG2;

  logic signed [SumW-1:0] acc_q, acc_d, sample_ext, acc_sum;
  logic [WIN_LOG2-1:0]    cnt_q, cnt_d;
  logic                   win_done_q;
  logic signed [SumW-1:0] win_sum_q;

  assign sample_ext  = {{WIN_LOG2{sample_i[SAMPLE_W-1]}}, sample_i};
  assign acc_sum     = acc_q + sample_ext;
  assign close_o     = sample_valid_i && !clear_i && (cnt_q == '1);
  assign close_sum_o = acc_sum;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (sample_valid_i) begin
      cnt_d = cnt_q + 1'b1;
      // The closing sample completes this window; the next one starts from zero.
      acc_d = close_o ? '0 : acc_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      win_done_q <= 1'b0;
      win_sum_q  <= '0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      win_done_q <= close_o;
      if (close_o) win_sum_q <= acc_sum;
    end
  end

  assign win_done_o = win_done_q;
  assign win_sum_o  = win_sum_q;

endmodule

// File: rtl/motor_fault_classifier.sv
// Motor fault classifier: sums fixed-length windows of valid samples,
// classifies each window sum, debounces the class and reports a confirmed
// fault code. An idle timeout drops the lock.
//   clk, rst        clock, synchronous active-high reset
//   sample_valid_i  sample qualifier
//   sample_i        signed motor sample
//   win_done_o      pulse: window result on win_sum_o / win_class_o
//   win_sum_o       signed window sum
//   win_class_o     raw class of last window
//   fault_code_o    confirmed class
//   fault_valid_o   fault_code_o is confirmed and current
//   fault_change_o  pulse: fault_code_o took a new value
//   timeout_o       pulse: idle timeout fired
module motor_fault_classifier
  import motor_fault_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned WIN_LOG2   = 4,
  parameter int unsigned CONFIRM    = 2,
  parameter int unsigned TIMEOUT    = 64,
  parameter int          TH_STATOR  = DEF_TH_STATOR,
  parameter int          TH_BEARING = DEF_TH_BEARING,
  parameter int          TH_ROTOR   = DEF_TH_ROTOR
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                sample_valid_i,
  input  logic signed [SAMPLE_W-1:0]          sample_i,
  output logic                                win_done_o,
  output logic signed [SAMPLE_W+WIN_LOG2-1:0] win_sum_o,
  output logic [1:0]                          win_class_o,
  output logic [1:0]                          fault_code_o,
  output logic                                fault_valid_o,
  output logic                                fault_change_o,
  output logic                                timeout_o
);

  localparam int unsigned SumW   = SAMPLE_W + WIN_LOG2;
  localparam int unsigned AgreeW = $clog2(CONFIRM + 1);
  localparam int unsigned IdleW  = $clog2(TIMEOUT + 1);

  logic                   close;
  logic signed [SumW-1:0] close_sum;
  logic [1:0]             class_now;
  logic                   tmo_hit;

  logic [IdleW-1:0]  idle_q, idle_d;
  state_e            state_q;
  logic [1:0]        prev_q, win_class_q, fault_code_q;
  logic [AgreeW-1:0] agree_q, agree_next;
  logic              fault_valid_q, fault_change_q, timeout_q;
  logic              confirmed;

  window_accumulator #(
    .SAMPLE_W (SAMPLE_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_acc (
    .clk            (clk),
    .rst            (rst),
    .clear_i        (tmo_hit),
    .sample_valid_i (sample_valid_i),
    .sample_i       (sample_i),
    .close_o        (close),
    .close_sum_o    (close_sum),
    .win_done_o     (win_done_o),
    .win_sum_o      (win_sum_o)
  );

  // Classify in the closing cycle so the debounce result lands with win_done.
  assign class_now = classify(int'(close_sum), TH_STATOR, TH_BEARING, TH_ROTOR);

  assign tmo_hit = !sample_valid_i && (idle_q == IdleW'(TIMEOUT - 1));

  always_comb begin
    idle_d = idle_q + 1'b1;
    if (sample_valid_i || tmo_hit) idle_d = '0;
  end

  always_comb begin
    agree_next = AgreeW'(1);
    if (class_now == prev_q) begin
      agree_next = (agree_q == AgreeW'(CONFIRM)) ? agree_q : agree_q + 1'b1;
    end
  end

  assign confirmed = (agree_next == AgreeW'(CONFIRM));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StAcq;
      idle_q         <= '0;
      prev_q         <= FAULT_HEALTHY;
      agree_q        <= '0;
      win_class_q    <= FAULT_HEALTHY;
      fault_code_q   <= FAULT_HEALTHY;
      fault_valid_q  <= 1'b0;
      fault_change_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      idle_q         <= idle_d;
      fault_change_q <= 1'b0;
      timeout_q      <= tmo_hit;
      if (tmo_hit) begin
        // fault_code is kept; only the lock and the debounce history are dropped.
        state_q       <= StAcq;
        fault_valid_q <= 1'b0;
        agree_q       <= '0;
      end else if (close) begin
        win_class_q <= class_now;
        unique case (state_q)
          StAcq: begin
            prev_q  <= class_now;
            agree_q <= agree_next;
            if (confirmed) begin
              fault_code_q   <= class_now;
              fault_valid_q  <= 1'b1;
              fault_change_q <= 1'b1;
              state_q        <= StLock;
            end
          end
          StLock: begin
            prev_q <= class_now;
            if (class_now == fault_code_q) begin
              agree_q <= AgreeW'(CONFIRM);
            end else begin
              agree_q <= agree_next;
              if (confirmed) begin
                fault_code_q   <= class_now;
                fault_change_q <= 1'b1;
              end
            end
          end
          default: state_q <= StAcq;
        endcase
      end
    end
  end

  assign win_class_o    = win_class_q;
  assign fault_code_o   = fault_code_q;
  assign fault_valid_o  = fault_valid_q;
  assign fault_change_o = fault_change_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_motor_fault_classifier.sv
// Self-checking bench for motor_fault_classifier. A window-level reference
// model (sums, class history, idle run length) tracks the expected outputs.
module tb_motor_fault_classifier;

  localparam int CONFIRM = 2;
  localparam int TIMEOUT = 64;
  localparam int WIN     = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sample_valid = 1'b0;
  logic signed [15:0] sample = '0;
  logic               win_done_o;
  logic signed [19:0] win_sum_o;
  logic [1:0]         win_class_o, fault_code_o;
  logic               fault_valid_o, fault_change_o, timeout_o;

  int checks = 0;
  int errors = 0;
  int gidx = 0;
  logic [1:0] cur_mode = 2'd0;

  always #5 clk = ~clk;

  motor_fault_classifier dut (
    .clk            (clk),
    .rst            (rst),
    .sample_valid_i (sample_valid),
    .sample_i       (sample),
    .win_done_o     (win_done_o),
    .win_sum_o      (win_sum_o),
    .win_class_o    (win_class_o),
    .fault_code_o   (fault_code_o),
    .fault_valid_o  (fault_valid_o),
    .fault_change_o (fault_change_o),
    .timeout_o      (timeout_o)
  );

  // ---------------- reference model ----------------
  logic       exp_done = 0, exp_fv = 0, exp_change = 0, exp_tmo = 0;
  logic [1:0] exp_class = 0, exp_code = 0;
  int         exp_sum = 0;
  int         m_acc = 0, m_n = 0, m_idle = 0;
  bit         m_locked = 0;
  logic [1:0] hist[$];

  function automatic logic [1:0] ref_class(input int s);
    if (s <= -2400) return 2'b11;
    if (s >= 2800) return 2'b01;
    if (s >= 1200) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_done = 0; exp_fv = 0; exp_change = 0; exp_tmo = 0;
      exp_class = 0; exp_code = 0; exp_sum = 0;
      m_acc = 0; m_n = 0; m_idle = 0; m_locked = 0;
      hist.delete();
    end else begin
      exp_done = 0; exp_change = 0; exp_tmo = 0;
      if (sample_valid) begin
        m_idle = 0;
        m_acc += int'(sample);
        m_n++;
        if (m_n == WIN) begin
          bit same;
          exp_done  = 1;
          exp_sum   = m_acc;
          exp_class = ref_class(m_acc);
          m_acc = 0;
          m_n   = 0;
          hist.push_back(exp_class);
          if (hist.size() > 8) void'(hist.pop_front());
          // Confirmed when the last CONFIRM windows since the last timeout agree.
          same = (hist.size() >= CONFIRM);
          for (int i = 0; i < CONFIRM && same; i++)
            if (hist[hist.size() - 1 - i] != exp_class) same = 0;
          if (same && (!m_locked || exp_class != exp_code)) begin
            exp_code   = exp_class;
            exp_fv     = 1;
            exp_change = 1;
            m_locked   = 1;
          end
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          exp_tmo = 1; exp_fv = 0; m_locked = 0;
          m_idle = 0; m_acc = 0; m_n = 0;
          hist.delete();
        end
      end
    end
  end

  logic [27:0] obs_vec, exp_vec;
  assign obs_vec = {win_done_o, win_sum_o, win_class_o, fault_code_o, fault_valid_o,
                    fault_change_o, timeout_o};
  assign exp_vec = {exp_done, exp_sum[19:0], exp_class, exp_code, exp_fv, exp_change, exp_tmo};

  // ---------------- stimulus ----------------
  // Zero-sum alternating +-1000 carrier plus a per-mode offset giving the
  // nominal window sums 0 / 3200 / 2400 / -4800.
  function automatic int gen(input logic [1:0] m, input int k);
    int off;
    case (m)
      2'd1:    off = 200;
      2'd2:    off = 150;
      2'd3:    off = -300;
      default: off = 0;
    endcase
    return (((k % 2) == 0) ? 1000 : -1000) + off;
  endfunction

  task automatic tick(input logic v, input int noise);
    sample_valid = v;
    if (v) begin
      sample = 16'(gen(cur_mode, gidx) + noise);
      gidx++;
    end else begin
      sample = 16'($urandom);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      sample = 16'($urandom);
      @(negedge clk);
      checks++;
      if (obs_vec !== 28'd0) begin
        errors++;
        $display("FAIL reset_outputs got %h want 0", obs_vec);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_healthy();
    int changes = 0;
    cur_mode = 2'd0;
    do_reset();
    for (int c = 1; c <= 32; c++) begin
      tick(1'b1, 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL healthy_model cyc %0d got %h want %h", c + 1, obs_vec, exp_vec);
      end
      checks++;
      if (win_done_o !== (c + 1 == 17 || c + 1 == 33) || fault_valid_o !== (c + 1 == 33)) begin
        errors++;
        $display("FAIL healthy_timing cyc %0d got done=%b fv=%b", c + 1, win_done_o,
                 fault_valid_o);
      end
      if (win_done_o) begin
        checks++;
        if (win_sum_o !== 20'sd0) begin
          errors++;
          $display("FAIL healthy_sum got %0d want 0", win_sum_o);
        end
      end
      if (fault_change_o) changes++;
    end
    checks++;
    if (fault_code_o !== 2'b00 || changes != 1) begin
      errors++;
      $display("FAIL healthy_lock got code=%b changes=%0d want code=00 changes=1",
               fault_code_o, changes);
    end
  endtask

  task automatic test_modes();
    int want_sum[4] = '{0, 3200, 2400, -4800};
    for (int m = 1; m <= 3; m++) begin
      cur_mode = 2'(m);
      do_reset();
      for (int c = 1; c <= 32; c++) begin
        tick(1'b1, 0);
        checks++;
        if (obs_vec !== exp_vec) begin
          errors++;
          $display("FAIL mode%0d_model cyc %0d got %h want %h", m, c + 1, obs_vec, exp_vec);
        end
      end
      checks++;
      if (win_done_o !== 1'b1 || win_sum_o !== 20'(want_sum[m]) || fault_code_o !== 2'(m)
          || fault_valid_o !== 1'b1 || win_class_o !== 2'(m)) begin
        errors++;
        $display("FAIL mode%0d_result got sum=%0d code=%b fv=%b want sum=%0d code=%0d fv=1",
                 m, win_sum_o, fault_code_o, fault_valid_o, want_sum[m], m);
      end
    end
  endtask

  task automatic test_switch();
    cur_mode = 2'd0;
    do_reset();
    for (int c = 1; c <= 80; c++) begin
      if (c == 41) cur_mode = 2'd3;  // mid-window in the third window
      tick(1'b1, 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL switch_model cyc %0d got %h want %h", c + 1, obs_vec, exp_vec);
      end
      if (c >= 32) begin
        checks++;
        if (fault_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL switch_fv cyc %0d got %b want 1", c + 1, fault_valid_o);
        end
      end
      if (c == 48) begin
        checks++;
        if (win_done_o !== 1'b1 || fault_code_o !== 2'b00) begin
          errors++;
          $display("FAIL switch_mixed got done=%b code=%b want done=1 code=00",
                   win_done_o, fault_code_o);
        end
      end
    end
    checks++;
    if (fault_code_o !== 2'b11) begin
      errors++;
      $display("FAIL switch_final got code=%b want 11", fault_code_o);
    end
  endtask

  task automatic test_half_valid();
    int done_at[$];
    cur_mode = 2'd1;
    do_reset();
    for (int c = 1; c <= 66; c++) begin
      tick(1'((c % 2) == 1), 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL half_model cyc %0d got %h want %h", c + 1, obs_vec, exp_vec);
      end
      if (win_done_o) begin
        done_at.push_back(c);
        checks++;
        if (win_sum_o !== 20'sd3200) begin
          errors++;
          $display("FAIL half_sum got %0d want 3200", win_sum_o);
        end
      end
    end
    checks++;
    if (done_at.size() != 2 || done_at[1] - done_at[0] != 32) begin
      errors++;
      $display("FAIL half_spacing got %0d windows want 2 spaced 32", done_at.size());
    end
  endtask

  task automatic test_timeout();
    int tmo = 0;
    cur_mode = 2'd2;
    do_reset();
    for (int c = 1; c <= 134; c++) begin
      tick(1'(c <= 32 || c > 102), 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL timeout_model cyc %0d got %h want %h", c + 1, obs_vec, exp_vec);
      end
      if (timeout_o) tmo++;
      if (c == 96) begin
        checks++;
        if (timeout_o !== 1'b1 || fault_valid_o !== 1'b0 || fault_code_o !== 2'b10) begin
          errors++;
          $display("FAIL timeout_fire got tmo=%b fv=%b code=%b want 1 0 10",
                   timeout_o, fault_valid_o, fault_code_o);
        end
      end
    end
    checks++;
    if (tmo != 1 || fault_valid_o !== 1'b1 || fault_code_o !== 2'b10) begin
      errors++;
      $display("FAIL timeout_relock got pulses=%0d fv=%b code=%b want 1 1 10",
               tmo, fault_valid_o, fault_code_o);
    end
  endtask

  task automatic test_mid_reset();
    cur_mode = 2'd1;
    do_reset();
    for (int c = 1; c <= 7; c++) tick(1'b1, 0);
    cur_mode = 2'd3;
    do_reset();
    checks++;
    if (obs_vec !== 28'd0) begin
      errors++;
      $display("FAIL midreset_outputs got %h want 0", obs_vec);
    end
    for (int c = 1; c <= 16; c++) begin
      tick(1'b1, 0);
      checks++;
      if (win_done_o !== (c == 16)) begin
        errors++;
        $display("FAIL midreset_done cyc %0d got %b", c + 1, win_done_o);
      end
    end
    checks++;
    if (win_sum_o !== -20'sd4800 || win_class_o !== 2'b11) begin
      errors++;
      $display("FAIL midreset_sum got %0d class %b want -4800 11", win_sum_o, win_class_o);
    end
  endtask

  task automatic test_random();
    int burst = 0;
    do_reset();
    for (int c = 1; c <= 1500; c++) begin
      logic v;
      if ($urandom_range(0, 39) == 0) cur_mode = 2'($urandom);
      if (burst > 0) begin
        burst--;
        v = 1'b0;
      end else if ($urandom_range(0, 149) == 0) begin
        burst = int'($urandom_range(55, 75));
        v = 1'b0;
      end else begin
        v = 1'($urandom_range(0, 3) != 0);
      end
      tick(v, int'($urandom_range(0, 600)) - 300);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL random_model cyc %0d got %h want %h", c + 1, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_healthy();
    test_modes();
    test_switch();
    test_half_valid();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
